alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 180 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered single-stage ALU with valid/ready handshakes on both sides.
// Ops: add/sub, and/or, xor/lui, and shifts (logical left/right, arithmetic right).
// Flags z, c, v, n are registered together with the result.
// Optional build macro ALU_PIPE_MUL_EN adds an iterative unsigned multiplier.
// The multiplier takes aluc = 4'b1x00 and uses a shift-add loop of WIDTH cycles.
//
// Multiplier FSM (ALU_PIPE_MUL_EN only):
//   state   | meaning
//   IDLE    | no multiply in flight, ALU accepts new ops
//   MUL     | one shift-add step per cycle, WIDTH steps, down-counter to zero
//   DONE    | product ready, waits for a free output register
module alu_pipe #(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       aluc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic             n
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_res;
   logic             r_z, r_c, r_v, r_n;

   logic             w_accept;
   logic             w_busy;
   logic             w_is_mul;
   logic             w_mul_load;
   logic [WIDTH-1:0] w_mul_res;
   logic             w_mul_c;

   logic                    w_sub;
   logic [WIDTH-1:0]        w_b_eff;
   logic [WIDTH:0]          w_sum;
   logic [SHW-1:0]          w_shamt;
   logic signed [WIDTH-1:0] w_b_signed;
   logic [WIDTH-1:0]        w_res;
   logic                    w_c, w_v;

   assign in_ready  = !w_busy && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_out_valid;
   assign r         = r_res;
   assign z         = r_z;
   assign c         = r_c;
   assign v         = r_v;
   assign n         = r_n;

   // subtraction reuses the adder as a + ~b + 1, so c=1 means no borrow
   assign w_sub      = aluc[2];
   assign w_b_eff    = w_sub ? ~b : b;
   assign w_sum      = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
   assign w_shamt    = a[SHW-1:0];
   assign w_b_signed = b;

   // single-cycle result and carry/overflow selection by opcode
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (aluc[1:0])
         2'b00: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         2'b01: w_res = aluc[2] ? (a | b) : (a & b);
         2'b11: w_res = aluc[2] ? {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}} : (a ^ b);
         2'b10: begin
            if (!aluc[2])
               w_res = b << w_shamt;
            else if (!aluc[3])
               w_res = b >> w_shamt;
            else
               w_res = w_b_signed >>> w_shamt;
         end
         default: w_res = '0;
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

   state_t             r_state;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mplier;
   logic [SHW-1:0]     r_cnt;

   assign w_is_mul   = aluc[3] && (aluc[1:0] == 2'b00);
   assign w_busy     = (r_state != ST_IDLE);
   assign w_mul_load = (r_state == ST_DONE) && (!r_out_valid || out_ready);
   assign w_mul_res  = r_prod[WIDTH-1:0];
   assign w_mul_c    = |r_prod[2*WIDTH-1:WIDTH];

   // shift-add multiplier sequencing; reset aborts any multiply in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_mcand  <= {{WIDTH{1'b0}}, a};
                  r_mplier <= b;
                  r_prod   <= '0;
                  r_cnt    <= SHW'(WIDTH - 1);
                  r_state  <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (r_mplier[0])
                  r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (r_cnt == '0)
                  r_state <= ST_DONE;
               else
                  r_cnt <= r_cnt - SHW'(1);
            end
            ST_DONE: begin
               if (w_mul_load)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
`else
   assign w_is_mul   = 1'b0;
   assign w_busy     = 1'b0;
   assign w_mul_load = 1'b0;
   assign w_mul_res  = '0;
   assign w_mul_c    = 1'b0;
`endif

   // output register: loads on accept (or finished multiply), holds under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
         r_v         <= 1'b0;
         r_n         <= 1'b0;
      end else if (w_mul_load) begin
         r_out_valid <= 1'b1;
         r_res       <= w_mul_res;
         r_z         <= (w_mul_res == '0);
         r_c         <= w_mul_c;
         r_v         <= 1'b0;
         r_n         <= w_mul_res[WIDTH-1];
      end else if (w_accept && !w_is_mul) begin
         r_out_valid <= 1'b1;
         r_res       <= w_res;
         r_z         <= (w_res == '0);
         r_c         <= w_c;
         r_v         <= w_v;
         r_n         <= w_res[WIDTH-1];
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: table vectors, handshake corner cases, random stream.
// Expected results go into a scoreboard queue on acceptance and are checked on transfer.
module tb_alu_pipe;
   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, r;
   logic [3:0]   aluc;
   logic         z, c, v, n;

   typedef struct packed {
      logic [W-1:0] r;
      logic         z, c, v, n;
   } res_t;

   typedef struct {
      logic [W-1:0] a, b;
      logic [3:0]   aluc;
      res_t         exp;
   } vec_t;

   res_t exp_q[$];
   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   logic s_in_ready, s_out_valid;
   res_t s_out;

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .aluc(aluc),
      .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .z(z), .c(c), .v(v), .n(n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Independent reference: wide/signed integer arithmetic rather than adder tricks.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [3:0] op);
      res_t           o;
      logic [W:0]     u;
      logic [2*W-1:0] p;
      longint         sa, sbv, ss, lim, t;
      int             sh;
      o   = '0;
      sa  = longint'($signed(ma));
      sbv = longint'($signed(mb));
      lim = longint'(1) <<< (W - 1);
      sh  = int'(ma % W);
      p   = '0;
      case (op[1:0])
         2'b00: begin
`ifdef ALU_PIPE_MUL_EN
            if (op[3]) begin
               p   = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
               o.r = p[W-1:0];
               o.c = |p[2*W-1:W];
            end else
`endif
            if (!op[2]) begin
               u   = {1'b0, ma} + {1'b0, mb};
               o.r = u[W-1:0];
               o.c = u[W];
               ss  = sa + sbv;
               o.v = (ss >= lim) || (ss < -lim);
            end else begin
               o.r = ma - mb;
               o.c = (ma >= mb);
               ss  = sa - sbv;
               o.v = (ss >= lim) || (ss < -lim);
            end
         end
         2'b01: o.r = op[2] ? (ma | mb) : (ma & mb);
         2'b11: o.r = op[2] ? (mb << (W / 2)) : (ma ^ mb);
         default: begin
            if (!op[2]) o.r = mb << sh;
            else if (!op[3]) o.r = mb >> sh;
            else begin
               t   = sbv >>> sh;
               o.r = t[W-1:0];
            end
         end
      endcase
      o.z = (o.r == '0);
      o.n = o.r[W-1];
      return o;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [3:0] op,
                               input logic [W-1:0] er, input logic ez, input logic ec,
                               input logic ev, input logic en);
      vec_t x;
      x.a = va; x.b = vb; x.aluc = op;
      x.exp = {er, ez, ec, ev, en};
      return x;
   endfunction

   // One cycle: drive at negedge, sample mid-cycle, score transfer, push on accept.
   task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] iop, input logic ordy, input res_t exp);
      res_t e;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      aluc      = iop;
      out_ready = ordy;
      #1;
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_out       = {r, z, c, v, n};
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_out: got result %h with no op pending", s_out);
         end else begin
            e = exp_q.pop_front();
            check("result", s_out, e);
         end
      end
      if (iv && in_ready) exp_q.push_back(exp);
   endtask

   initial begin
      int   seen;
      int   lat;
      int   bad;
      logic [W-1:0] ra, rb;
      logic [3:0]   rop;

      rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; aluc = '0; out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_result", {r, z, c, v, n}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_in_ready", in_ready, 1);

      vecs.push_back(mk(32'hFFFFFFFF, 32'h1,        4'b0000, 32'h0,        1, 1, 0, 0));
      vecs.push_back(mk(32'h7FFFFFFF, 32'h1,        4'b0000, 32'h80000000, 0, 0, 1, 1));
      vecs.push_back(mk(32'h5,        32'h7,        4'b0100, 32'hFFFFFFFE, 0, 0, 0, 1));
      vecs.push_back(mk(32'h4,        32'h80000000, 4'b1110, 32'hF8000000, 0, 0, 0, 1));
      vecs.push_back(mk(32'h4,        32'h80000000, 4'b0110, 32'h08000000, 0, 0, 0, 0));
      vecs.push_back(mk(32'h4,        32'h80000000, 4'b0010, 32'h0,        1, 0, 0, 0));
      vecs.push_back(mk(32'h4,        32'h00001234, 4'b0111, 32'h12340000, 0, 0, 0, 0));
      vecs.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hF000F000, 0, 0, 0, 1));
      vecs.push_back(mk(32'h0F0F0000, 32'h000000F0, 4'b0101, 32'h0F0F00F0, 0, 0, 0, 0));
      vecs.push_back(mk(32'hFFFF0000, 32'hFFFF0000, 4'b0011, 32'h0,        1, 0, 0, 0));
      vecs.push_back(mk(32'h7,        32'h7,        4'b0100, 32'h0,        1, 1, 0, 0));
      vecs.push_back(mk(32'h80000000, 32'h1,        4'b0100, 32'h7FFFFFFF, 0, 1, 1, 0));
      vecs.push_back(mk(32'h1F,       32'h1,        4'b0010, 32'h80000000, 0, 0, 0, 1));
      vecs.push_back(mk(32'h21,       32'h1,        4'b0010, 32'h2,        0, 0, 0, 0));
`ifdef ALU_PIPE_MUL_EN
      vecs.push_back(mk(32'h1,        32'h2,        4'b1000, 32'h2,        0, 0, 0, 0));
`else
      vecs.push_back(mk(32'h1,        32'h2,        4'b1000, 32'h3,        0, 0, 0, 0));
      vecs.push_back(mk(32'h1,        32'h2,        4'b1100, 32'hFFFFFFFF, 0, 0, 0, 1));
`endif

      foreach (vecs[i]) begin
         for (int k = 0; k < 60 && !in_ready; k++) step(0, '0, '0, '0, 1, '0);
         step(1, vecs[i].a, vecs[i].b, vecs[i].aluc, 1, vecs[i].exp);
      end
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) step(0, '0, '0, '0, 1, '0);
      check("table_drained", exp_q.size(), 0);

      // latency: result visible and held the cycle after accept
      step(1, 32'hFFFFFFFF, 32'h1, 4'b0000, 0, model(32'hFFFFFFFF, 32'h1, 4'b0000));
      step(0, '0, '0, '0, 0, '0);
      check("latency_out_valid", s_out_valid, 1);
      check("latency_result", s_out, {32'h0, 1'b1, 1'b1, 1'b0, 1'b0});
      check("latency_in_ready_blocked", s_in_ready, 0);
      step(0, '0, '0, '0, 1, '0);

      // backpressure: three stalled cycles with in_valid held
      step(1, 32'd11, 32'd22, 4'b0000, 1, model(32'd11, 32'd22, 4'b0000));
      for (int k = 0; k < 3; k++) begin
         step(1, 32'd100, 32'd200, 4'b0000, 0, model(32'd100, 32'd200, 4'b0000));
         check("bp_in_ready", s_in_ready, 0);
         check("bp_hold_r", s_out.r, 32'd33);
         check("bp_out_valid", s_out_valid, 1);
      end
      step(1, 32'd100, 32'd200, 4'b0000, 1, model(32'd100, 32'd200, 4'b0000));
      check("bp_release_in_ready", s_in_ready, 1);
      step(1, 32'h7, 32'h9, 4'b0101, 1, model(32'h7, 32'h9, 4'b0101));
      step(0, '0, '0, '0, 1, '0);
      check("bp_last_out_valid", s_out_valid, 1);
      step(0, '0, '0, '0, 1, '0);
      check("bp_drained", exp_q.size(), 0);
      check("bp_idle_out_valid", s_out_valid, 0);

      // random stream with random consumer stalls
      for (int i = 0; i < 300; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = 4'($urandom_range(0, 15));
         if (($urandom_range(0, 3)) == 0) ra = ra % W;
         step(($urandom_range(0, 3) != 0), ra, rb, rop, ($urandom_range(0, 2) != 0),
              model(ra, rb, rop));
      end
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(0, '0, '0, '0, 1, '0);
      check("random_drained", exp_q.size(), 0);

      // reset while a result is pending discards it
      step(1, 32'h5, 32'h3, 4'b0000, 0, model(32'h5, 32'h3, 4'b0000));
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midreset_out_valid", out_valid, 0);
      check("midreset_r", r, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midreset_in_ready", in_ready, 1);

`ifdef ALU_PIPE_MUL_EN
      // multiply latency WIDTH+1, busy throughout
      step(1, 32'h00010000, 32'h00010000, 4'b1000, 1, {32'h0, 1'b1, 1'b1, 1'b0, 1'b0});
      lat = 0;
      bad = 0;
      step(0, '0, '0, '0, 1, '0);
      while (!s_out_valid && lat < 100) begin
         lat++;
         if (s_in_ready) bad++;
         step(0, '0, '0, '0, 1, '0);
      end
      check("mul_latency", lat, W + 1);
      check("mul_busy_in_ready", bad, 0);
      step(0, '0, '0, '0, 1, '0);

      // reset mid-multiply aborts with no result
      step(1, 32'h00010000, 32'h00010000, 4'b1000, 1, {32'h0, 1'b1, 1'b1, 1'b0, 1'b0});
      repeat (4) step(0, '0, '0, '0, 1, '0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         step(0, '0, '0, '0, 1, '0);
         if (s_out_valid) seen++;
      end
      check("mul_abort_no_out", seen, 0);
      check("mul_abort_in_ready", s_in_ready, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish within time limit, required finish");
      $fatal(1);
   end

endmodule
